// File: rtl/hc85_seq_cmp.sv
// Sequencer that performs a WIDTH-bit unsigned magnitude compare on one external HC85
// 4-bit comparator slice, one nibble per clock, LSB nibble first, cascading through registers.
module hc85_seq_cmp #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             BUSY,
    output logic             DONE,
    output logic             AGB,
    output logic             ASB,
    output logic             AEB,
    output logic             ERR,
    output logic [3:0]       CMP_A,
    output logic [3:0]       CMP_B,
    output logic             CMP_IAGB,
    output logic             CMP_IASB,
    output logic             CMP_IAEB,
    input  logic             CMP_QAGB,
    input  logic             CMP_QASB,
    input  logic             CMP_QAEB
);

    localparam int NIB = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [2:0]       q_resp;
    logic             accept;
    logic             last_nib;

    function automatic logic one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    assign q_resp   = {CMP_QAGB, CMP_QASB, CMP_QAEB};
    assign accept   = (state == S_IDLE) && START;
    assign last_nib = (idx == LAST_IDX);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (START) state_next = S_COMPARE;
            S_COMPARE: if (last_nib) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Control: state, nibble index, cascade registers, held results and error flag
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
            idx   <= '0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            AGB   <= 1'b0;
            ASB   <= 1'b0;
            AEB   <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        idx          <= '0;
                        {gt, lt, eq} <= 3'b001;
                        ERR          <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    {gt, lt, eq} <= q_resp;
                    ERR          <= ERR | ~one_hot3(q_resp);
                    // Final slice response is the full-width result; publish it as DONE rises
                    if (last_nib) begin
                        {AGB, ASB, AEB} <= q_resp;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture: data only, loaded on the accepting edge
    always_ff @(posedge CLK) begin
        if (accept) begin
            opa_q <= OPA;
            opb_q <= OPB;
        end
    end

    always_comb begin
        BUSY     = (state != S_IDLE);
        DONE     = (state == S_DONE);
        CMP_A    = 4'b0000;
        CMP_B    = 4'b0000;
        CMP_IAGB = 1'b0;
        CMP_IASB = 1'b0;
        CMP_IAEB = 1'b0;
        if (state == S_COMPARE) begin
            CMP_A    = 4'(opa_q >> {idx, 2'b00});
            CMP_B    = 4'(opb_q >> {idx, 2'b00});
            CMP_IAGB = gt;
            CMP_IASB = lt;
            CMP_IAEB = eq;
        end
    end

endmodule

// File: tb/tb_hc85_seq_cmp.sv
// Directed bench for hc85_seq_cmp with a behavioural HC85 slice on the CMP_* ports.
module tb_hc85_seq_cmp;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [15:0] OPA;
    logic [15:0] OPB;
    logic        BUSY, DONE, AGB, ASB, AEB, ERR;
    logic [3:0]  CMP_A, CMP_B;
    logic        CMP_IAGB, CMP_IASB, CMP_IAEB;
    logic        CMP_QAGB, CMP_QASB, CMP_QAEB;
    logic        force_zero;
    int          n_checks;
    int          n_fail;

    hc85_seq_cmp #(.WIDTH(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPA(OPA), .OPB(OPB),
        .BUSY(BUSY), .DONE(DONE), .AGB(AGB), .ASB(ASB), .AEB(AEB), .ERR(ERR),
        .CMP_A(CMP_A), .CMP_B(CMP_B),
        .CMP_IAGB(CMP_IAGB), .CMP_IASB(CMP_IASB), .CMP_IAEB(CMP_IAEB),
        .CMP_QAGB(CMP_QAGB), .CMP_QASB(CMP_QASB), .CMP_QAEB(CMP_QAEB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // 74HC85 truth table, with an override that drives all outputs low
    always_comb begin
        if (force_zero)                {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b000;
        else if (CMP_A > CMP_B)        {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b100;
        else if (CMP_A < CMP_B)        {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b010;
        else if (CMP_IAEB)             {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b001;
        else if (CMP_IAGB && !CMP_IASB) {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b100;
        else if (!CMP_IAGB && CMP_IASB) {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b010;
        else if (CMP_IAGB && CMP_IASB)  {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b000;
        else                           {CMP_QAGB, CMP_QASB, CMP_QAEB} = 3'b110;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse START for one edge with the given operands; return the edge count at which DONE
    // was observed (accept edge = 1), or -1 if it never arrived within the budget.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int done_cyc);
        int cyc;
        OPA   = a;
        OPB   = b;
        START = 1'b1;
        tick();
        START = 1'b0;
        cyc   = 1;
        while (!DONE && cyc < 20) begin
            tick();
            cyc++;
        end
        done_cyc = DONE ? cyc : -1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({BUSY, DONE, AGB, ASB, AEB, ERR} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {BUSY, DONE, AGB, ASB, AEB, ERR});
        end
        n_checks++;
        if ({CMP_A, CMP_B, CMP_IAGB, CMP_IASB, CMP_IAEB} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_cmp_bus: got %h expected 000", {CMP_A, CMP_B, CMP_IAGB, CMP_IASB, CMP_IAEB});
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_nibble_order();
        int dc;
        OPA   = 16'h1234;
        OPB   = 16'h5678;
        START = 1'b1;
        tick();
        START = 1'b0;
        n_checks++;
        if ({CMP_A, CMP_B, CMP_IAGB, CMP_IASB, CMP_IAEB} !== {4'h4, 4'h8, 3'b001}) begin
            n_fail++;
            $display("FAIL nib0_bus: got %h/%h/%b expected 4/8/001", CMP_A, CMP_B, {CMP_IAGB, CMP_IASB, CMP_IAEB});
        end
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL nib0_busy: got %b expected 1", BUSY);
        end
        tick();
        n_checks++;
        if ({CMP_A, CMP_B, CMP_IAGB, CMP_IASB, CMP_IAEB} !== {4'h3, 4'h7, 3'b010}) begin
            n_fail++;
            $display("FAIL nib1_bus: got %h/%h/%b expected 3/7/010", CMP_A, CMP_B, {CMP_IAGB, CMP_IASB, CMP_IAEB});
        end
        dc = 0;
        while (!DONE && dc < 20) begin
            tick();
            dc++;
        end
        n_checks++;
        if ({DONE, AGB, ASB, AEB} !== 4'b1010) begin
            n_fail++;
            $display("FAIL nib_result: got %b expected 1010", {DONE, AGB, ASB, AEB});
        end
        tick();
    endtask

    task automatic test_equal();
        int dc;
        do_op(16'hA5A5, 16'hA5A5, dc);
        n_checks++;
        if (dc !== 5) begin
            n_fail++;
            $display("FAIL eq_latency: got %0d expected 5", dc);
        end
        n_checks++;
        if ({BUSY, AGB, ASB, AEB, ERR} !== 5'b10010) begin
            n_fail++;
            $display("FAIL eq_result: got %b expected 10010", {BUSY, AGB, ASB, AEB, ERR});
        end
        tick();
        n_checks++;
        if ({BUSY, DONE, AGB, ASB, AEB} !== 5'b00001) begin
            n_fail++;
            $display("FAIL eq_hold: got %b expected 00001", {BUSY, DONE, AGB, ASB, AEB});
        end
    endtask

    task automatic test_msb_decides();
        int dc;
        do_op(16'h8000, 16'h7FFF, dc);
        n_checks++;
        if (dc !== 5 || {AGB, ASB, AEB} !== 3'b100) begin
            n_fail++;
            $display("FAIL msb_gt: got cyc=%0d res=%b expected cyc=5 res=100", dc, {AGB, ASB, AEB});
        end
        tick();
    endtask

    task automatic test_lsb_cascade();
        int dc;
        do_op(16'h1234, 16'h1235, dc);
        n_checks++;
        if (dc !== 5 || {AGB, ASB, AEB} !== 3'b010) begin
            n_fail++;
            $display("FAIL lsb_lt: got cyc=%0d res=%b expected cyc=5 res=010", dc, {AGB, ASB, AEB});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        OPA   = 16'h0100;
        OPB   = 16'h00FF;
        START = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) OPA = 16'h0010;
            if (c == 7) OPA = 16'hFFFF;
            if (DONE) begin
                ndone++;
                if (ndone == 1) begin
                    n_checks++;
                    if (c != 5 || {AGB, ASB, AEB} !== 3'b100) begin
                        n_fail++;
                        $display("FAIL b2b_first: got cyc=%0d res=%b expected cyc=5 res=100", c, {AGB, ASB, AEB});
                    end
                end else if (ndone == 2) begin
                    n_checks++;
                    if (c != 11 || {AGB, ASB, AEB} !== 3'b010) begin
                        n_fail++;
                        $display("FAIL b2b_second: got cyc=%0d res=%b expected cyc=11 res=010", c, {AGB, ASB, AEB});
                    end
                end
            end
        end
        START = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (DONE) ndone++;
        end
        n_checks++;
        if (ndone != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 2", ndone);
        end
    endtask

    task automatic test_reset_mid_op();
        int dc;
        int extra;
        OPA   = 16'h4444;
        OPB   = 16'h1111;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        RST_N = 1'b0;
        tick();
        n_checks++;
        if ({BUSY, DONE, AGB, ASB, AEB, ERR} !== 6'b0 || CMP_A !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b/%h expected 000000/0", {BUSY, DONE, AGB, ASB, AEB, ERR}, CMP_A);
        end
        RST_N = 1'b1;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (DONE || BUSY) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got %0d active cycles expected 0", extra);
        end
        do_op(16'h0005, 16'h0003, dc);
        n_checks++;
        if (dc !== 5 || {AGB, ASB, AEB} !== 3'b100) begin
            n_fail++;
            $display("FAIL midrst_restart: got cyc=%0d res=%b expected cyc=5 res=100", dc, {AGB, ASB, AEB});
        end
        tick();
    endtask

    task automatic test_err();
        int dc;
        OPA   = 16'hA5A5;
        OPB   = 16'hA5A5;
        START = 1'b1;
        tick();
        START      = 1'b0;
        force_zero = 1'b1;
        tick();
        force_zero = 1'b0;
        dc = 2;
        while (!DONE && dc < 20) begin
            tick();
            dc++;
        end
        n_checks++;
        if (dc !== 5 || ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got cyc=%0d err=%b expected cyc=5 err=1", dc, ERR);
        end
        tick();
        n_checks++;
        if (ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", ERR);
        end
        OPA   = 16'h0F0F;
        OPB   = 16'h0F0F;
        START = 1'b1;
        tick();
        START = 1'b0;
        n_checks++;
        if (ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", ERR);
        end
        dc = 1;
        while (!DONE && dc < 20) begin
            tick();
            dc++;
        end
        n_checks++;
        if (dc !== 5 || {AGB, ASB, AEB, ERR} !== 4'b0010) begin
            n_fail++;
            $display("FAIL err_clean_op: got cyc=%0d res=%b expected cyc=5 res=0010", dc, {AGB, ASB, AEB, ERR});
        end
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        RST_N      = 1'b0;
        START      = 1'b0;
        OPA        = '0;
        OPB        = '0;
        force_zero = 1'b0;
        test_reset();
        test_nibble_order();
        test_equal();
        test_msb_decides();
        test_lsb_cascade();
        test_back_to_back();
        test_reset_mid_op();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
